// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a small instruction FIFO feeding decode.
// Owns the fetch PC and keeps at most one imem request outstanding. FIFO
// space is reserved before a request goes out, so a returning word always
// has room. On a redirect the FIFO is flushed and any in-flight response
// is discarded.
// Optional build macro: IF_JAL_PREDECODE_EN. When defined, a pushed JAL
// retargets the fetch PC in the push cycle.
//
// state | meaning
// IDLE  | no request issued (FIFO has no free credit, or just out of reset)
// REQ   | imem_req high, holding imem_addr until imem_ready
// WAIT  | request accepted, waiting for imem_rvalid
// DROP  | waiting for a stale response to discard after a redirect
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int          PW  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   req_pc;
  logic [CW-1:0] count, count_next;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic accept, push, pop, credit;
  logic unused_redirect_bits;

  assign accept = (state == REQ) && imem_ready;
  assign push   = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign pop    = id_valid && id_ready && !redirect_valid;
  assign credit = count_next < CW'(DEPTH);
  assign unused_redirect_bits = ^redirect_pc[1:0];

`ifdef IF_JAL_PREDECODE_EN
  logic        is_jal;
  logic [31:0] jal_imm;
  assign is_jal  = imem_rdata[6:2] == 5'b11011;
  assign jal_imm = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                    imem_rdata[20], imem_rdata[30:21], 1'b0};
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // FIFO occupancy after this cycle's push/pop/flush
  always_comb begin
    count_next = count;
    if (redirect_valid)   count_next = '0;
    else if (push && !pop) count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic; a redirect always leaves the FIFO empty so credit holds
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (credit) state_next = REQ;
      REQ:  if (imem_ready) state_next = redirect_valid ? DROP : WAIT;
      WAIT: begin
        if (redirect_valid)   state_next = imem_rvalid ? REQ : DROP;
        else if (imem_rvalid) state_next = credit ? REQ : IDLE;
      end
      DROP: if (imem_rvalid) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req = (state == REQ);
  end

  assign imem_addr = fetch_pc;

  // Fetch PC: redirect wins, then JAL predecode (if built), then sequential advance
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_valid) fetch_pc_next = {redirect_pc[31:2], 2'b00};
`ifdef IF_JAL_PREDECODE_EN
    else if (push && is_jal) fetch_pc_next = req_pc + jal_imm;
`endif
    else if (accept) fetch_pc_next = fetch_pc + 32'd4;
  end

  // Fetch PC, accepted-request PC and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      if (accept) req_pc <= fetch_pc;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // FIFO storage; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]   <= req_pc;
    end
  end

  assign id_valid = (count != '0);
  assign id_inst  = id_valid ? inst_q[rd_ptr] : NOP;
  assign id_pc    = id_valid ? pc_q[rd_ptr] : 32'h0;

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage feeding the decode stage (immediate extension, register read) of the 5-stage pipeline.
- Owns the fetch PC and issues word requests to instruction memory over a req/ready + rvalid handshake, one request outstanding at most.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution: flushes the FIFO and drops any stale in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, instruction FIFO entries; legal values 2..8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address; equals the fetch PC.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; arrives at least 1 cycle after acceptance.
- imem_rdata  in  32  returned instruction.
- redirect_valid  in  1  pipeline redirect, one-cycle pulse.
- redirect_pc  in  32  redirect target.
- id_valid  out  1  head instruction valid.
- id_inst  out  32  head instruction; 32'h0000_0013 (NOP) when FIFO empty.
- id_pc  out  32  PC of head instruction; 0 when empty.
- id_ready  in  1  decode consumes head; low means stall.

Behaviour:
- Reset, asynchronous:
  - fetch PC = RESET_PC; FIFO count = 0; FSM = IDLE.
  - imem_req = 0, id_valid = 0, id_inst = NOP, id_pc = 0.
- FSM states:
  - IDLE: no request issued.
  - REQ: imem_req = 1, waiting for imem_ready.
  - WAIT: request accepted, waiting for imem_rvalid.
  - DROP: waiting for a stale response to discard.
- Credit rule: a request is issued only when FIFO count + (1 if a request is in WAIT) < DEPTH. The FIFO can therefore never overflow.
- IDLE → REQ when the credit rule allows. The first request is raised the cycle after rst_n deasserts.
- REQ: imem_addr is held stable until imem_ready. On acceptance: fetch PC += 4 (wraps at 2^32), REQ → WAIT.
- WAIT on imem_rvalid:
  - push {accepted PC, imem_rdata} into the FIFO.
  - Next state is REQ if credit allows, else IDLE. Back-to-back, this gives one instruction every 2 cycles with 1-cycle memory.
- Pop: the head is removed when id_valid && id_ready. Push and pop in the same cycle are both performed; count is unchanged.
- Fetch-to-decode latency: id_valid rises the cycle after the rvalid push (FIFO output is registered).
- Redirect, when redirect_valid = 1:
  - FIFO cleared, so id_valid = 0 next cycle.
  - fetch PC ← {redirect_pc[31:2], 2'b00}.
  - From WAIT: go to DROP. If imem_rvalid arrives in the same cycle as the redirect, that response is discarded and the FSM goes to REQ instead.
  - From REQ: the unaccepted request is retargeted; the next cycle presents the new address. If imem_ready is high in the redirect cycle, the old request counts as accepted and the FSM goes to DROP.
  - From IDLE or DROP: go to REQ, or stay in DROP, respectively.
  - Redirect beats a simultaneous pop and a simultaneous push.
- DROP: the next imem_rvalid is discarded, then DROP → REQ with the redirected PC.
- Stall: while id_ready = 0, id_valid, id_inst and id_pc hold. Fetch continues until the FIFO is full, then stays in IDLE.

Optional Feature:
- Macro: IF_JAL_PREDECODE_EN.
- Defined:
  - A pushed instruction with inst[6:2] = 5'b11011 (JAL) sets the fetch PC to pushed_pc + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - This happens in the push cycle, replacing sequential fetch.
  - No outstanding request can exist at that point, so no drop is needed.
  - An external redirect in the same cycle takes priority.
- Undefined: fetch is purely sequential; JAL is resolved downstream via redirect.

Test Plan:
- Reset + sequential fetch: RESET_PC = 0, 1-cycle memory, id_ready = 1 → requests to addresses 0, 4, 8, 12; id_pc sequence 0, 4, 8; first id_valid 3 cycles after reset release.
- Stall/full: id_ready = 0, DEPTH = 2 → exactly 2 pushes, then imem_req stays 0. Raise id_ready → pops at 0, then 4; fetch resumes at 8.
- Redirect during WAIT: redirect_pc = 32'h100 while a response is pending → stale rdata discarded, next imem_addr = 32'h100, id_pc = 32'h100 with no stale entry.
- Redirect coincident with rvalid and pop: rdata discarded, FIFO empty next cycle, next request to the target.
- Misaligned redirect 32'h203 → fetch at 32'h200. Reset asserted in WAIT → all outputs at reset values immediately, and the late rvalid is ignored.
- With IF_JAL_PREDECODE_EN: JAL at pc 32'h40 with offset +32'h20 → next imem_addr = 32'h60.
